// File: rtl/dmem_bus_responder.sv
// Data-memory bus responder: accepts one read/write request at a time, answers after
// WAIT_STATES wait cycles with a one-cycle ack, and flags illegal requests with err.
module dmem_bus_responder #(
    parameter int WORD_SIZE   = 19,
    parameter int ADDR_SIZE   = 19,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 ack,
    output logic                 err,
    output logic                 busy
);

    localparam int                   IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [3:0]           WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_SIZE-1:0] ADDR_LIMIT = ADDR_SIZE'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state, state_next;
    logic [3:0]           wait_cnt;
    logic                 cap_rd, cap_wr;
    logic [ADDR_SIZE-1:0] cap_addr;
    logic [WORD_SIZE-1:0] cap_wdata;
    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

    logic                 accept, enter_resp, req_bad;
    logic                 eff_rd, eff_wr;
    logic [ADDR_SIZE-1:0] eff_addr;
    logic [WORD_SIZE-1:0] eff_wdata;
    logic [IDX_W-1:0]     idx;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: if (rd_en || wr_en) begin
                accept     = 1'b1;
                state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: if (wait_cnt == 4'd0) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // With zero wait states the response edge is the accept edge, so use the live inputs.
    always_comb begin
        eff_rd     = accept ? rd_en   : cap_rd;
        eff_wr     = accept ? wr_en   : cap_wr;
        eff_addr   = accept ? address : cap_addr;
        eff_wdata  = accept ? wdata   : cap_wdata;
        idx        = eff_addr[IDX_W-1:0];
        req_bad    = (eff_rd && eff_wr) || (eff_addr >= ADDR_LIMIT);
        enter_resp = (state_next == S_RESP);
    end

    assign busy = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 4'd0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            wait_cnt  <= WAIT_LOAD;
            cap_rd    <= rd_en;
            cap_wr    <= wr_en;
            cap_addr  <= address;
            cap_wdata <= wdata;
        end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt  <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            if (enter_resp) begin
                ack <= 1'b1;
                err <= req_bad;
                if (!req_bad && eff_rd) rdata <= mem[idx];
            end
        end
    end

    // NOTE: the array must read as zero after reset, so it is built from resettable flops, not RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (enter_resp && eff_wr && !req_bad) begin
            mem[idx] <= eff_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Scoreboard bench for dmem_bus_responder: a WAIT_STATES=2 instance under directed and
// random traffic, plus a WAIT_STATES=0 instance for back-to-back held reads.
module tb_dmem_bus_responder;

    localparam int WS = 2;

    typedef struct {
        logic        err;
        logic [18:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en, wr_en, ack, err, busy;
    logic [18:0] address, wdata, rdata;
    logic        rd_en0, wr_en0, ack0, err0, busy0;
    logic [18:0] address0, wdata0, rdata0;

    exp_t        q[$];
    exp_t        q0[$];
    exp_t        mon_e, mon_e0;
    logic [18:0] model [1024];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dmem_bus_responder #(.WORD_SIZE(19), .ADDR_SIZE(19), .MEM_DEPTH(1024), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    dmem_bus_responder #(.WORD_SIZE(19), .ADDR_SIZE(19), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .rd_en(rd_en0), .wr_en(wr_en0), .address(address0),
        .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop an expectation on every ack, otherwise outputs must be quiet.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
            else begin
                mon_e = q.pop_front();
                check("resp_err", 32'(err), 32'(mon_e.err));
                check("resp_rdata", 32'(rdata), 32'(mon_e.rdata));
            end
        end else begin
            check("quiet_outputs", 32'({ack, err, rdata}), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (ack0 === 1'b1) begin
            if (q0.size() == 0) check("ws0_unexpected_ack", 32'd1, 32'd0);
            else begin
                mon_e0 = q0.pop_front();
                check("ws0_err", 32'(err0), 32'(mon_e0.err));
                check("ws0_rdata", 32'(rdata0), 32'(mon_e0.rdata));
            end
        end else begin
            check("ws0_quiet", 32'({ack0, err0, rdata0}), 32'd0);
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) model[i] = '0;
    endtask

    // Expected response from the rules: reject both-enables or out-of-range, else read/write the word.
    task automatic predict(input logic rd, input logic wr, input logic [18:0] a, input logic [18:0] d);
        exp_t e;
        logic is_err;
        is_err  = (rd && wr) || (a >= 19'd1024);
        e.err   = is_err;
        e.rdata = (!is_err && rd) ? model[a[9:0]] : 19'd0;
        if (!is_err && wr) model[a[9:0]] = d;
        q.push_back(e);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [18:0] a, input logic [18:0] d);
        int n;
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = a; wdata = d;
        predict(rd, wr, a, d);
        @(posedge clk);
        #1 address = 19'($urandom); wdata = 19'($urandom);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            check("busy_during", 32'(busy), 32'd1);
            if (ack === 1'b1) break;
        end
        check("ack_latency", 32'(n), 32'(WS + 1));
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    logic [18:0] ra, rdat;
    int          kind, sel, n, first_ack;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rd_en = 0; wr_en = 0; address = 0; wdata = 0;
        rd_en0 = 0; wr_en0 = 0; address0 = 0; wdata0 = 0;
        clear_model();
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_rdata_err", 32'({err, rdata}), 32'd0);
        reset = 1'b0;

        do_req(0, 1, 19'd3, 19'h5A5A5);
        do_req(1, 0, 19'd3, 19'h0);
        do_req(0, 1, 19'd7, 19'h00001);
        do_req(1, 1, 19'd7, 19'h12345);
        do_req(1, 0, 19'd7, 19'h0);
        do_req(0, 1, 19'd0, 19'h2468A);
        do_req(0, 1, 19'd1024, 19'h3);
        do_req(0, 1, 19'h40005, 19'h7);
        do_req(1, 0, 19'd0, 19'h0);
        do_req(1, 0, 19'd5, 19'h0);
        do_req(0, 1, 19'd1023, 19'h7FFFF);
        do_req(1, 0, 19'd1023, 19'h0);

        // Late drop: a read held through the cycle after ack is accepted again.
        @(negedge clk);
        rd_en = 1'b1; address = 19'd3;
        predict(1, 0, 19'd3, 19'h0);
        predict(1, 0, 19'd3, 19'h0);
        n = 0; first_ack = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (ack === 1'b1) begin
                if (first_ack == 0) first_ack = n;
                else break;
            end
        end
        check("late_drop_gap", 32'(n - first_ack), 32'(WS + 2));
        rd_en = 1'b0;
        @(negedge clk);

        // Reset while the write waits: nothing commits and no ack appears.
        @(negedge clk);
        wr_en = 1'b1; address = 19'd9; wdata = 19'h7FFFF;
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        repeat (6) @(negedge clk);
        do_req(1, 0, 19'd9, 19'h0);

        for (int i = 0; i < 120; i++) begin
            kind = $urandom_range(0, 19);
            sel  = $urandom_range(0, 9);
            if (sel <= 5)      ra = 19'($urandom_range(0, 15));
            else if (sel == 6) ra = 19'($urandom_range(1008, 1023));
            else if (sel == 7) ra = 19'($urandom_range(1024, 1027));
            else if (sel == 8) ra = 19'($urandom);
            else               ra = 19'($urandom_range(0, 1023));
            rdat = 19'($urandom);
            if (kind < 9)       do_req(1, 0, ra, rdat);
            else if (kind < 18) do_req(0, 1, ra, rdat);
            else                do_req(1, 1, ra, rdat);
        end
        check("queue_drained", 32'(q.size()), 32'd0);

        // Zero wait states: one write, then reads held high ack every other cycle.
        do_reset();
        rdat = 19'($urandom);
        @(negedge clk);
        wr_en0 = 1'b1; address0 = 19'd5; wdata0 = rdat;
        q0.push_back('{err: 1'b0, rdata: 19'd0});
        @(posedge clk);
        #1 wr_en0 = 1'b0;
        @(negedge clk);
        check("ws0_write_ack", 32'(ack0), 32'd1);
        @(negedge clk);
        rd_en0 = 1'b1; address0 = 19'd5;
        for (int i = 0; i < 6; i++) q0.push_back('{err: 1'b0, rdata: rdat});
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("ws0_ack_pattern", 32'(ack0), 32'(i % 2));
        end
        rd_en0 = 1'b0;
        repeat (3) @(negedge clk);
        check("ws0_queue_drained", 32'(q0.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
